seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the match-counter width (legal range 1..8).
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_valid  input  1  qualifies i_data for the current cycle.
REQ-007 i_data  input  1  serial data bit.
REQ-008 i_load  input  1  latches i_pattern and flushes history.
REQ-009 i_pattern  input  PAT_W  target sequence; MSB is the earliest bit received.
REQ-010 i_clr  input  1  clears the match counter and the saturation flag.
REQ-011 o_valid  output  1  i_valid delayed one cycle.
REQ-012 o_en  output  1  one-cycle match pulse.
REQ-013 o_cnt  output  CNT_W  saturating count of matches.
REQ-014 o_sat  output  1  high while o_cnt equals 2^CNT_W-1.

Function
REQ-015 The block SHALL hold a PAT_W-bit history register (hist) and a fill counter (fill, 0..PAT_W).
REQ-016 The block SHALL hold a pattern register (pat).
REQ-017 FSM states SHALL be EMPTY (fill=0), FILLING (0<fill<PAT_W) and ARMED (fill=PAT_W).
REQ-018 On an i_valid cycle without i_load, the block SHALL set hist <= {hist[PAT_W-2:0], i_data}.
REQ-019 On the same cycle, fill SHALL increment and saturate at PAT_W.
REQ-020 State transitions: EMPTY->FILLING on first valid bit; FILLING->ARMED when fill reaches PAT_W; ARMED stays ARMED.
REQ-021 A match SHALL occur on an edge where i_valid=1, the post-shift fill equals PAT_W, and the post-shift hist equals pat.
REQ-022 On a match, o_en SHALL be 1 for exactly the following cycle (registered, latency 1); otherwise o_en SHALL be 0.
REQ-023 Cycles with i_valid=0 SHALL leave hist, fill and the FSM unchanged and force o_en=0 next cycle.
REQ-024 OVERLAP=1: after a match, hist and fill SHALL be kept, so the next match may share bits (1101101 gives two matches for 1101).
REQ-025 OVERLAP=0: on a match, fill SHALL go to 0 and the FSM to EMPTY, so the next match needs PAT_W fresh bits.
REQ-026 i_load=1 SHALL load pat <= i_pattern, set hist=0 and fill=0, and enter EMPTY.
REQ-027 i_load has priority over i_valid in the same cycle; the data bit is discarded and no match can occur.
REQ-028 On a match, o_cnt SHALL increment by 1 and saturate at 2^CNT_W-1; o_sat SHALL be registered alongside o_cnt.
REQ-029 i_clr=1 SHALL set o_cnt=0 and o_sat=0.
REQ-030 If i_clr and a match occur in the same cycle, i_clr wins: o_cnt=0 and o_en still pulses.
REQ-031 i_load SHALL NOT affect o_cnt.
REQ-032 o_valid SHALL be registered i_valid, independent of all other controls.

Reset
REQ-033 While i_rst_n=0 at a rising edge, the block SHALL set o_valid=0, o_en=0, o_cnt=0, o_sat=0, hist=0, fill=0, FSM=EMPTY.
REQ-034 While i_rst_n=0 at a rising edge, the block SHALL set pat to {PAT_W{1'b0}}.
REQ-035 Reset SHALL override i_load, i_clr and i_valid.
REQ-036 Reset asserted mid-sequence SHALL discard partial history; the first match after release needs PAT_W new valid bits.

Verification
REQ-037 PAT_W=4, OVERLAP=1, load 1101, stream 1101101 on consecutive valids -> o_en pulses the cycles after bits 4 and 7; o_cnt=2.
REQ-038 Same stream with OVERLAP=0 -> single o_en after bit 4; o_cnt=1.
REQ-039 Pattern 1101, bits 1,1 / i_valid low 3 cycles / 0,1 -> o_en pulses once after the final bit; no pulse during the gap.
REQ-040 CNT_W=3, 9 matches -> o_cnt steps 1..7 and holds 7; o_sat=1 from the 7th match.
REQ-041 Match coincident with i_clr -> o_cnt=0, o_sat=0, o_en=1.
REQ-042 Reset asserted after bits 1,1,0 of pattern 1101 -> no match on the next single 1; match after a fresh 1101.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with saturating match counter
module seq_detect_param #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 3,
    parameter int OVERLAP = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_data,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_clr,
    output logic             o_valid,
    output logic             o_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_ARMED   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PAT_W-1:0]    r_hist;
    logic [PAT_W-1:0]    w_hist_nxt;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic [PAT_W-1:0]    r_pat;
    logic [PAT_W-1:0]    w_pat_nxt;
    logic                r_valid;
    logic                r_en;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_sat;
    logic                w_sat_nxt;
    logic                w_match;
    logic [PAT_W-1:0]    w_hist_shift;
    logic [FILL_W-1:0]   w_fill_inc;

    // Post-shift history/fill as seen by the match comparator
    assign w_hist_shift = {r_hist[PAT_W-2:0], i_data};
    assign w_fill_inc   = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    assign w_match      = i_valid && !i_load && (w_fill_inc == FILL_FULL) && (w_hist_shift == r_pat);

    // Next-state: load flushes, valid shifts, non-overlap mode restarts after a match
    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_pat_nxt   = r_pat;
        if (i_load) begin
            w_pat_nxt   = i_pattern;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = S_EMPTY;
        end else if (i_valid) begin
            w_hist_nxt = w_hist_shift;
            w_fill_nxt = w_fill_inc;
            case (r_state)
                S_EMPTY:   w_state_nxt = (w_fill_inc == FILL_FULL) ? S_ARMED : S_FILLING;
                S_FILLING: w_state_nxt = (w_fill_inc == FILL_FULL) ? S_ARMED : S_FILLING;
                S_ARMED:   w_state_nxt = S_ARMED;
                default:   w_state_nxt = S_EMPTY;
            endcase
            if (w_match && (OVERLAP == 0)) begin
                w_fill_nxt  = '0;
                w_state_nxt = S_EMPTY;
            end
        end
    end

    // Counter next value: clear beats a coincident match; saturates at all-ones
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        w_sat_nxt = (w_cnt_nxt == CNT_MAX);
    end

    // State, history and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_valid <= 1'b0;
            r_en    <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_pat   <= w_pat_nxt;
            r_valid <= i_valid;
            r_en    <= w_match;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_en    = r_en;
    assign o_cnt   = r_cnt;
    assign o_sat   = r_sat;

endmodule
